aes_sbox_gen: RTL



---
 rtl/aes_const.sv | 28 ++
 rtl/aes_wire.sv | 17 +
 rtl/aes_gf_step.sv | 51 +++++
 rtl/aes_sbox_gen.sv | 122 ++++++++++++
 4 files changed

// File: rtl/aes_const.sv
// ---------------------------------------------------------------------------
// aes_const
// Shared AES constants plus a small helper for the S-box affine transform.
//   SBOX_AFFINE : additive constant of the affine step (8'h63)
//   GF_POLY     : low byte of the AES reduction polynomial x^8+x^4+x^3+x+1
//   SBOX_SIZE   : number of entries in each substitution table
// ---------------------------------------------------------------------------
package aes_const;

    localparam logic [7:0] SBOX_AFFINE = 8'h63;
    localparam logic [7:0] GF_POLY     = 8'h1B;
    localparam int         SBOX_SIZE   = 256;

    // Affine step of the S-box: b ^ rotl(b,1) ^ rotl(b,2) ^ rotl(b,3)
    // ^ rotl(b,4) ^ 8'h63, with all rotations written as 8-bit concatenations.
    function automatic logic [7:0] sboxAffine(input logic [7:0] b);
        logic [7:0] rot1;
        logic [7:0] rot2;
        logic [7:0] rot3;
        logic [7:0] rot4;
        rot1 = {b[6:0], b[7]};
        rot2 = {b[5:0], b[7:6]};
        rot3 = {b[4:0], b[7:5]};
        rot4 = {b[3:0], b[7:4]};
        return b ^ rot1 ^ rot2 ^ rot3 ^ rot4 ^ SBOX_AFFINE;
    endfunction

endpackage

// File: rtl/aes_wire.sv
// ---------------------------------------------------------------------------
// aes_wire
// Shared AES type definitions.
//   sbox_gen_state_t : states of the S-box table generator
//     INIT - seed entry 0 and the walk registers
//     RUN  - one generator-3 step and one table write per cycle
//     DONE - tables complete, waiting for a regeneration request
// ---------------------------------------------------------------------------
package aes_wire;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sbox_gen_state_t;

endpackage

// File: rtl/aes_gf_step.sv
// ---------------------------------------------------------------------------
// aes_gf_step
// One combinational step of the GF(2^8) generator-3 walk used to build the
// AES S-box. p walks the powers of 3, q walks the powers of 3^-1, so q is
// always the multiplicative inverse of p and the S-box entry for p is simply
// the affine transform of q.
// Ports:
//   i_p     [7:0] current power of 3
//   i_q     [7:0] current inverse of i_p
//   o_pNext [7:0] i_p * 3 mod 0x11B
//   o_qNext [7:0] i_q / 3 mod 0x11B (inverse of o_pNext)
//   o_sbox  [7:0] S-box value for o_pNext
// ---------------------------------------------------------------------------
module aes_gf_step
    import aes_const::*;
(
    input  logic [7:0] i_p,
    input  logic [7:0] i_q,
    output logic [7:0] o_pNext,
    output logic [7:0] o_qNext,
    output logic [7:0] o_sbox
);

    logic [7:0] w_pDouble;
    logic [7:0] w_t0;
    logic [7:0] w_t1;
    logic [7:0] w_t2;

    // Multiply by 3 = (p * 2) ^ p, where p * 2 reduces by the AES polynomial
    // whenever the top bit falls off.
    always_comb begin
        w_pDouble = {i_p[6:0], 1'b0} ^ (i_p[7] ? GF_POLY : 8'h00);
        o_pNext   = w_pDouble ^ i_p;
    end

    // Divide by 3: the shift/xor cascade multiplies by the inverse of 3 in
    // carry-less form, and the final 8'h09 correction folds the reduction
    // back in when bit 7 of the intermediate is set.
    always_comb begin
        w_t0    = i_q ^ {i_q[6:0], 1'b0};
        w_t1    = w_t0 ^ {w_t0[5:0], 2'b00};
        w_t2    = w_t1 ^ {w_t1[3:0], 4'b0000};
        o_qNext = w_t2[7] ? (w_t2 ^ 8'h09) : w_t2;
    end

    // S-box value of the new p is the affine image of its inverse.
    always_comb begin
        o_sbox = sboxAffine(o_qNext);
    end

endmodule

// File: rtl/aes_sbox_gen.sv
// ---------------------------------------------------------------------------
// aes_sbox_gen
// Sequential generator for the AES forward and inverse S-box tables.
// After reset, and on each start request taken in DONE, the block writes
// entry 0 in one INIT cycle and then the other 255 entries in 255 RUN
// cycles, one forward and one inverse entry per cycle. ready rises on the
// edge after the walk finishes and drops on the edge that accepts start.
// Ports:
//   clk       in   1            rising-edge clock
//   rst       in   1            asynchronous active-low reset
//   start     in   1            regeneration request, honoured only in DONE
//   S_Box     out  [7:0][0:255] forward S-box table (registered)
//   Inv_S_Box out  [7:0][0:255] inverse S-box table (registered)
//   ready     out  1            both tables complete and valid (registered)
// ---------------------------------------------------------------------------
module aes_sbox_gen
    import aes_const::*;
    import aes_wire::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] S_Box     [0:SBOX_SIZE-1],
    output logic [7:0] Inv_S_Box [0:SBOX_SIZE-1],
    output logic       ready
);

    sbox_gen_state_t r_state;
    sbox_gen_state_t w_stateNext;

    logic [7:0] r_p;
    logic [7:0] r_q;
    logic       r_ready;

    logic [7:0] w_pNext;
    logic [7:0] w_qNext;
    logic [7:0] w_sboxVal;

    aes_gf_step u_gfStep (
        .i_p     (r_p),
        .i_q     (r_q),
        .o_pNext (w_pNext),
        .o_qNext (w_qNext),
        .o_sbox  (w_sboxVal)
    );

    // State register. Reset always returns to INIT so generation restarts
    // on the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= INIT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic. The walk of powers of 3 returns to 1 after exactly
    // 255 steps, which is what ends RUN. start is only looked at in DONE,
    // so pulses arriving in INIT or RUN are simply dropped.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            INIT: w_stateNext = RUN;
            RUN: begin
                if (w_pNext == 8'h01) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_stateNext = INIT;
                end
            end
            default: w_stateNext = INIT;
        endcase
    end

    // Walk registers and table storage. INIT seeds the zero entry (which
    // the walk never reaches since 0 has no inverse) and reloads p = q = 1.
    // Each RUN cycle writes the S-box value for the next power of 3 and the
    // matching inverse entry. Untouched entries keep their old contents
    // during regeneration; consumers gate on ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            S_Box     <= '{default: 8'h00};
            Inv_S_Box <= '{default: 8'h00};
            r_p       <= 8'h01;
            r_q       <= 8'h01;
        end else begin
            case (r_state)
                INIT: begin
                    S_Box[8'h00]           <= SBOX_AFFINE;
                    Inv_S_Box[SBOX_AFFINE] <= 8'h00;
                    r_p                    <= 8'h01;
                    r_q                    <= 8'h01;
                end
                RUN: begin
                    S_Box[w_pNext]       <= w_sboxVal;
                    Inv_S_Box[w_sboxVal] <= w_pNext;
                    r_p                  <= w_pNext;
                    r_q                  <= w_qNext;
                end
                default: begin
                end
            endcase
        end
    end

    // ready is a registered view of "sitting in DONE with no new request".
    // That puts the rising edge one clock after the last write and makes it
    // fall on the same edge that accepts start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (r_state == DONE) && !start;
        end
    end

    assign ready = r_ready;

endmodule
